// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage register.
package pipe_pkg;

    // Occupancy of a pipeline stage: nothing held, main register held,
    // or main plus skid register held (skid variant only).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_WIDTH_DEFAULT = 96;
    localparam int PIPE_CNT_W_DEFAULT = 16;

    // True when a stage in state s presents a beat downstream.
    function automatic logic holds_beat(input pipe_state_t s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// cleared only by the asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualified cycles and hold once the maximum value is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating back-pressure counter.
//
// Handshake: a beat moves across a side on a rising edge where that side's
// valid and ready are both high. The source keeps valid and data stable
// until that edge; ready never depends on valid on the same side. Flush
// wins over the upstream handshake: a beat offered during flush is dropped
// even if in_ready reads 1, while the downstream transfer still completes.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT,
    parameter bit SKID  = 1'b1,
    parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cycles,
    output pipe_state_t      state
);

    // State register shared by both datapath variants.
    pipe_state_t      state_q;
    logic [WIDTH-1:0] main_q;
    logic             valid_q;

    assign state     = state_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

    generate
        if (SKID) begin : gen_skid
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;

            // Registered in_ready: low exactly while both entries are held.
            assign in_ready = ready_q;

            // Occupancy FSM with main/skid registers; bubbles are zero words.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end else if (flush) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_valid) begin
                                state_q <= BUSY;
                                main_q  <= in_data;
                                valid_q <= 1'b1;
                            end
                        end
                        BUSY: begin
                            if (in_valid && out_ready) begin
                                main_q <= in_data;
                            end else if (in_valid) begin
                                // Downstream stalled: park the new beat.
                                state_q <= FULL;
                                skid_q  <= in_data;
                                ready_q <= 1'b0;
                            end else if (out_ready) begin
                                state_q <= EMPTY;
                                main_q  <= '0;
                                valid_q <= 1'b0;
                            end
                        end
                        FULL: begin
                            if (out_ready) begin
                                state_q <= BUSY;
                                main_q  <= skid_q;
                                skid_q  <= '0;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= EMPTY;
                            main_q  <= '0;
                            skid_q  <= '0;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : gen_single
            // Combinational in_ready: accept when empty or when the held
            // beat leaves on this same edge.
            assign in_ready = ~valid_q | out_ready;

            // Two-state FSM; the main register loads on every upstream transfer.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_valid) begin
                                state_q <= BUSY;
                                main_q  <= in_data;
                                valid_q <= 1'b1;
                            end
                        end
                        BUSY: begin
                            if (in_valid && out_ready) begin
                                main_q <= in_data;
                            end else if (out_ready) begin
                                state_q <= EMPTY;
                                main_q  <= '0;
                                valid_q <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= EMPTY;
                            main_q  <= '0;
                            valid_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Back-pressure counter: one count per edge where a beat waits downstream.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (holds_beat(state_q) & ~out_ready),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: one SKID=1 instance and one SKID=0 instance
// (CNT_W=4), each with its own handshake signals and expected-beat queue.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int W = 96;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         iv1, ir1, ov1, or1;
    logic [W-1:0] id1, od1;
    logic [15:0]  stall1;
    pipe_state_t  st1;

    logic         iv0, ir0, ov0, or0;
    logic [W-1:0] id0, od0;
    logic [3:0]   stall0;
    pipe_state_t  st0;

    pipe_stage_skid #(.WIDTH(W), .SKID(1'b1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .stall_cycles(stall1), .state(st1)
    );

    pipe_stage_skid #(.WIDTH(W), .SKID(1'b0), .CNT_W(4)) u_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .stall_cycles(stall0), .state(st0)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int recv1  = 0;
    int recv0  = 0;
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];

    // Sampled at negedge: values that the next rising edge will act on.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            exp_q1.delete();
        end else begin
            if (ov1 && or1) begin
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL s1_unexpected_beat: got %h, expected no beat", od1);
                end else begin
                    e = exp_q1.pop_front();
                    recv1++;
                    if (od1 !== e) begin
                        errors++;
                        $display("FAIL s1_out_data: got %h, expected %h", od1, e);
                    end
                end
            end
            if (!ov1) begin
                checks++;
                if (od1 !== '0) begin
                    errors++;
                    $display("FAIL s1_bubble_zero: got %h, expected 0", od1);
                end
            end
            if (flush) exp_q1.delete();
            else if (iv1 && ir1) exp_q1.push_back(id1);
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            exp_q0.delete();
        end else begin
            if (ov0 && or0) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL s0_unexpected_beat: got %h, expected no beat", od0);
                end else begin
                    e = exp_q0.pop_front();
                    recv0++;
                    if (od0 !== e) begin
                        errors++;
                        $display("FAIL s0_out_data: got %h, expected %h", od0, e);
                    end
                end
            end
            if (!ov0) begin
                checks++;
                if (od0 !== '0) begin
                    errors++;
                    $display("FAIL s0_bubble_zero: got %h, expected 0", od0);
                end
            end
            if (flush) exp_q0.delete();
            else if (iv0 && ir0) exp_q0.push_back(id0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv1 = 1'b0; id1 = '0; or1 = 1'b1;
        iv0 = 1'b0; id0 = '0; or0 = 1'b1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_s1_out_valid: got %b, expected 0", ov1); end
        if (od1 !== '0) begin errors++; $display("FAIL reset_s1_out_data: got %h, expected 0", od1); end
        if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_s1_in_ready: got %b, expected 1", ir1); end
        if (stall1 !== 16'd0) begin errors++; $display("FAIL reset_s1_stall: got %0d, expected 0", stall1); end
        if (st1 !== EMPTY) begin errors++; $display("FAIL reset_s1_state: got %0d, expected %0d", st1, EMPTY); end
        if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_s0_in_ready: got %b, expected 1", ir0); end
        if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_s0_out_valid: got %b, expected 0", ov0); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        iv1 = 1'b1; id1 = W'(32'hA5); or1 = 1'b1;
        iv0 = 1'b1; id0 = W'(32'hA5); or0 = 1'b1;
        step();
        checks += 6;
        if (ov1 !== 1'b1) begin errors++; $display("FAIL single_s1_out_valid: got %b, expected 1", ov1); end
        if (od1 !== W'(32'hA5)) begin errors++; $display("FAIL single_s1_out_data: got %h, expected a5", od1); end
        if (stall1 !== 16'd0) begin errors++; $display("FAIL single_s1_stall: got %0d, expected 0", stall1); end
        if (ov0 !== 1'b1) begin errors++; $display("FAIL single_s0_out_valid: got %b, expected 1", ov0); end
        if (od0 !== W'(32'hA5)) begin errors++; $display("FAIL single_s0_out_data: got %h, expected a5", od0); end
        if (stall0 !== 4'd0) begin errors++; $display("FAIL single_s0_stall: got %0d, expected 0", stall0); end
        iv1 = 1'b0; iv0 = 1'b0;
        step();
        checks += 2;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL single_s1_drain: got %b, expected 0", ov1); end
        if (ov0 !== 1'b0) begin errors++; $display("FAIL single_s0_drain: got %b, expected 0", ov0); end
    endtask

    task automatic test_backpressure_skid();
        int idx = 0;
        int r0 = recv1;
        logic acc;
        for (int c = 0; c < 10; c++) begin
            iv1 = (idx < 4);
            id1 = W'(idx + 1);
            or1 = !(c >= 1 && c <= 3);
            #1;
            acc = iv1 && ir1;
            if (c == 1) begin
                checks++;
                if (ir1 !== 1'b1) begin errors++; $display("FAIL bp_s1_ready_drop_cycle: got %b, expected 1", ir1); end
            end
            if (c == 2) begin
                checks += 2;
                if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_s1_ready_after_drop: got %b, expected 0", ir1); end
                if (st1 !== FULL) begin errors++; $display("FAIL bp_s1_state_full: got %0d, expected %0d", st1, FULL); end
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        checks += 4;
        if (recv1 - r0 != 4) begin errors++; $display("FAIL bp_s1_beats_out: got %0d, expected 4", recv1 - r0); end
        if (stall1 !== 16'd3) begin errors++; $display("FAIL bp_s1_stall: got %0d, expected 3", stall1); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_s1_final_valid: got %b, expected 0", ov1); end
        if (exp_q1.size() != 0) begin errors++; $display("FAIL bp_s1_queue_left: got %0d, expected 0", exp_q1.size()); end
    endtask

    task automatic test_backpressure_single();
        int idx = 0;
        int r0 = recv0;
        logic acc;
        for (int c = 0; c < 10; c++) begin
            iv0 = (idx < 4);
            id0 = W'(idx + 1);
            or0 = !(c >= 1 && c <= 3);
            #1;
            acc = iv0 && ir0;
            if (c == 1) begin
                checks++;
                if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_s0_ready_same_cycle: got %b, expected 0", ir0); end
            end
            if (c == 4) begin
                checks++;
                if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_s0_ready_release: got %b, expected 1", ir0); end
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        checks += 3;
        if (recv0 - r0 != 4) begin errors++; $display("FAIL bp_s0_beats_out: got %0d, expected 4", recv0 - r0); end
        if (stall0 !== 4'd3) begin errors++; $display("FAIL bp_s0_stall: got %0d, expected 3", stall0); end
        if (exp_q0.size() != 0) begin errors++; $display("FAIL bp_s0_queue_left: got %0d, expected 0", exp_q0.size()); end
    endtask

    task automatic test_back_to_back();
        or1 = 1'b1; or0 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            iv1 = 1'b1; id1 = {$urandom, $urandom, $urandom};
            iv0 = 1'b1; id0 = {$urandom, $urandom, $urandom};
            #1;
            checks += 2;
            if (ir1 !== 1'b1) begin errors++; $display("FAIL b2b_s1_in_ready c%0d: got %b, expected 1", c, ir1); end
            if (ir0 !== 1'b1) begin errors++; $display("FAIL b2b_s0_in_ready c%0d: got %b, expected 1", c, ir0); end
            if (c > 0) begin
                checks += 2;
                if (ov1 !== 1'b1) begin errors++; $display("FAIL b2b_s1_out_valid c%0d: got %b, expected 1", c, ov1); end
                if (ov0 !== 1'b1) begin errors++; $display("FAIL b2b_s0_out_valid c%0d: got %b, expected 1", c, ov0); end
            end
            step();
        end
        iv1 = 1'b0; iv0 = 1'b0;
        step();
    endtask

    task automatic test_flush();
        iv1 = 1'b1; id1 = W'(32'h11); or1 = 1'b0;
        step();
        id1 = W'(32'h22);
        step();
        checks++;
        if (st1 !== FULL) begin errors++; $display("FAIL flush_setup_full: got %0d, expected %0d", st1, FULL); end
        flush = 1'b1; id1 = W'(32'h77);
        step();
        flush = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        checks += 4;
        if (st1 !== EMPTY) begin errors++; $display("FAIL flush_state: got %0d, expected %0d", st1, EMPTY); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, expected 0", ov1); end
        if (od1 !== '0) begin errors++; $display("FAIL flush_out_data: got %h, expected 0", od1); end
        if (ir1 !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, expected 1", ir1); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_no_ghost c%0d: got %b, expected 0", c, ov1); end
        end
        // Flush while a beat leaves downstream: that beat still completes.
        iv1 = 1'b1; id1 = W'(32'h33); or1 = 1'b1;
        step();
        flush = 1'b1; iv1 = 1'b1; id1 = W'(32'h44);
        begin
            int r0 = recv1;
            step();
            flush = 1'b0; iv1 = 1'b0;
            checks += 2;
            if (recv1 - r0 != 1) begin errors++; $display("FAIL flush_downstream_done: got %0d, expected 1", recv1 - r0); end
            if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_busy_empty: got %b, expected 0", ov1); end
        end
    endtask

    task automatic test_saturate();
        iv0 = 1'b1; id0 = W'(32'h5); or0 = 1'b0;
        step();
        iv0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 9) begin
                checks++;
                if (stall0 !== 4'd13) begin errors++; $display("FAIL sat_midway: got %0d, expected 13", stall0); end
            end
        end
        checks += 2;
        if (stall0 !== 4'd15) begin errors++; $display("FAIL sat_stop_at_max: got %0d, expected 15", stall0); end
        if (ov0 !== 1'b1) begin errors++; $display("FAIL sat_beat_held: got %b, expected 1", ov0); end
        or0 = 1'b1;
        step();
        checks++;
        if (stall0 !== 4'd15) begin errors++; $display("FAIL sat_hold_after_drain: got %0d, expected 15", stall0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            iv1 = ($urandom_range(0, 3) != 0); id1 = {$urandom, $urandom, $urandom};
            or1 = ($urandom_range(0, 2) != 0);
            iv0 = ($urandom_range(0, 3) != 0); id0 = {$urandom, $urandom, $urandom};
            or0 = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();
        repeat (4) step();
        checks += 4;
        if (exp_q1.size() != 0) begin errors++; $display("FAIL rand_s1_queue_left: got %0d, expected 0", exp_q1.size()); end
        if (exp_q0.size() != 0) begin errors++; $display("FAIL rand_s0_queue_left: got %0d, expected 0", exp_q0.size()); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL rand_s1_drained: got %b, expected 0", ov1); end
        if (ov0 !== 1'b0) begin errors++; $display("FAIL rand_s0_drained: got %b, expected 0", ov0); end
    endtask

    task automatic test_async_reset();
        iv1 = 1'b1; id1 = W'(32'h3C); or1 = 1'b0;
        iv0 = 1'b1; id0 = W'(32'h3C); or0 = 1'b0;
        step();
        iv1 = 1'b0; iv0 = 1'b0;
        checks++;
        if (st1 !== BUSY) begin errors++; $display("FAIL areset_setup_busy: got %0d, expected %0d", st1, BUSY); end
        #2;
        rst = 1'b0;
        #1;
        checks += 7;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL areset_s1_out_valid: got %b, expected 0", ov1); end
        if (od1 !== '0) begin errors++; $display("FAIL areset_s1_out_data: got %h, expected 0", od1); end
        if (st1 !== EMPTY) begin errors++; $display("FAIL areset_s1_state: got %0d, expected %0d", st1, EMPTY); end
        if (stall1 !== 16'd0) begin errors++; $display("FAIL areset_s1_stall: got %0d, expected 0", stall1); end
        if (ir1 !== 1'b1) begin errors++; $display("FAIL areset_s1_in_ready: got %b, expected 1", ir1); end
        if (ov0 !== 1'b0) begin errors++; $display("FAIL areset_s0_out_valid: got %b, expected 0", ov0); end
        if (stall0 !== 4'd0) begin errors++; $display("FAIL areset_s0_stall: got %0d, expected 0", stall0); end
        step();
        rst = 1'b1;
        iv1 = 1'b1; id1 = W'(32'h5A); or1 = 1'b1;
        step();
        iv1 = 1'b0;
        checks += 2;
        if (ov1 !== 1'b1) begin errors++; $display("FAIL areset_resume_valid: got %b, expected 1", ov1); end
        if (od1 !== W'(32'h5A)) begin errors++; $display("FAIL areset_resume_data: got %h, expected 5a", od1); end
        step();
        checks++;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL areset_resume_drain: got %b, expected 0", ov1); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_backpressure_skid();
        test_backpressure_single();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
